// File: rtl/string_tx_sequencer.sv
// string_tx_sequencer: sends "hello spence" (optionally followed by CR LF) byte by byte to a UART transmitter,
// with a one-deep queue for a trigger that arrives while a message is in flight.
module string_tx_sequencer #(
  parameter bit APPEND_CRLF = 1'b1,
  parameter int IDX_W       = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             en_i,
  input  logic             tx_busy_i,
  input  logic             tx_done_i,
  output logic [7:0]       tx_data_o,
  output logic             tx_start_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [IDX_W-1:0] char_idx_o
);
  localparam int LEN = APPEND_CRLF ? 14 : 12;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(LEN - 1);
  localparam logic [7:0] ROM [14] = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h73,
                                      8'h70, 8'h65, 8'h6E, 8'h63, 8'h65, 8'h0D, 8'h0A};
  typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_DONE, FINISH} state_t;
  state_t           state_q, state_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             pending_q, pending_d;
  logic             busy_q, done_q;
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      tx_data_q <= 8'h00;
      idx_q     <= '0;
      pending_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      busy_q    <= state_d != IDLE;
      done_q    <= state_d == FINISH;
    end
  end
  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    idx_d     = idx_q;
    pending_d = pending_q | (en_i & (state_q != IDLE));
    case (state_q)
      IDLE: begin
        state_d = en_i ? LOAD : IDLE;
        idx_d   = en_i ? '0 : idx_q;
      end
      LOAD: begin
        tx_data_d = ROM[idx_q];
        state_d   = SEND;
      end
      SEND:      state_d = tx_busy_i ? SEND : WAIT_DONE;
      WAIT_DONE: begin
        state_d = !tx_done_i ? WAIT_DONE : (idx_q == LAST) ? FINISH : LOAD;
        idx_d   = (tx_done_i && idx_q != LAST) ? idx_q + 1'b1 : idx_q;
      end
      FINISH: begin
        // an en seen here restarts at once; the queue is consumed either way
        state_d   = (pending_q | en_i) ? LOAD : IDLE;
        idx_d     = (pending_q | en_i) ? '0 : idx_q;
        pending_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  assign tx_start_o = (state_q == SEND) & ~tx_busy_i;
  assign tx_data_o  = tx_data_q;
  assign char_idx_o = idx_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
endmodule

// File: tb/tb_string_tx_sequencer.sv
// tb_string_tx_sequencer: directed checks of the message sequencer, with and without CR LF.
module tb_string_tx_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic       reset_i = 1'b1, en_i = 1'b0, tx_busy_i = 1'b0, tx_done_i = 1'b0;
  logic [7:0] tx_data_o;
  logic       tx_start_o, busy_o, done_o;
  logic [3:0] char_idx_o;
  logic       en0 = 1'b0, busy0_i = 1'b0, done0_i = 1'b0;
  logic [7:0] tx_data0;
  logic       tx_start0, busy0_o, done0_o;
  logic [3:0] char_idx0;
  string_tx_sequencer #(.APPEND_CRLF(1'b1), .IDX_W(4)) dut (
    .clk_i(clk), .reset_i(reset_i), .en_i(en_i), .tx_busy_i(tx_busy_i), .tx_done_i(tx_done_i),
    .tx_data_o(tx_data_o), .tx_start_o(tx_start_o), .busy_o(busy_o), .done_o(done_o), .char_idx_o(char_idx_o));
  string_tx_sequencer #(.APPEND_CRLF(1'b0), .IDX_W(4)) dut0 (
    .clk_i(clk), .reset_i(reset_i), .en_i(en0), .tx_busy_i(busy0_i), .tx_done_i(done0_i),
    .tx_data_o(tx_data0), .tx_start_o(tx_start0), .busy_o(busy0_o), .done_o(done0_o), .char_idx_o(char_idx0));
  logic [7:0] exp_msg [14] = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h73,
                               8'h70, 8'h65, 8'h6E, 8'h63, 8'h65, 8'h0D, 8'h0A};
  int errors = 0, checks = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic [7:0] st_data[$], st0_data[$];
  int st_cyc[$], dn_cyc[$], td_cyc[$];
  int dn0 = 0;
  always @(negedge clk) begin
    if (tx_start_o) begin st_data.push_back(tx_data_o); st_cyc.push_back(cyc); end
    if (done_o) dn_cyc.push_back(cyc);
    if (tx_done_i) td_cyc.push_back(cyc);
    if (tx_start0) st0_data.push_back(tx_data0);
    if (done0_o) dn0++;
  end
  // transmitter model: busy for 10 cycles after each accepted start, then one tx_done pulse
  bit model_on = 0;
  int cnt = 0;
  logic s;
  initial forever begin
    @(negedge clk);
    s = tx_start_o;
    @(posedge clk);
    #1;
    if (!model_on) cnt = 0;
    else if (s) begin tx_busy_i = 1'b1; cnt = 10; tx_done_i = 1'b0; end
    else if (cnt > 1) begin cnt--; tx_done_i = 1'b0; end
    else if (cnt == 1) begin cnt = 0; tx_busy_i = 1'b0; tx_done_i = 1'b1; end
    else tx_done_i = 1'b0;
  end
  initial begin #400000; $display("FAIL watchdog: simulation did not finish"); $fatal(1); end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic clear_logs();
    st_data.delete(); st_cyc.delete(); dn_cyc.delete(); td_cyc.delete(); st0_data.delete(); dn0 = 0;
  endtask
  task automatic pulse_en(output int k);
    k = cyc + 1;
    en_i = 1'b1;
    step();
    en_i = 1'b0;
  endtask
  task automatic do_reset();
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
  endtask
  task automatic test_reset();
    reset_i = 1'b1;
    step();
    step();
    @(negedge clk);
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    checks++; if (tx_data_o !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", tx_data_o); end
    checks++; if (char_idx_o !== 4'd0) begin errors++; $display("FAIL reset_idx: got %0d want 0", char_idx_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done_o); end
    checks++; if (tx_start_o !== 1'b0) begin errors++; $display("FAIL reset_start: got %b want 0", tx_start_o); end
    checks++; if (busy0_o !== 1'b0) begin errors++; $display("FAIL reset_busy0: got %b want 0", busy0_o); end
    step();
    reset_i = 1'b0;
  endtask
  task automatic test_single();
    int k;
    clear_logs();
    model_on = 1;
    pulse_en(k);
    for (int i = 0; i < 400 && dn_cyc.size() == 0; i++) step();
    repeat (3) step();
    checks++; if (st_data.size() !== 14) begin errors++; $display("FAIL single_count: got %0d want 14", st_data.size()); end
    for (int i = 0; i < 14; i++) begin
      logic [7:0] b;
      b = (i < st_data.size()) ? st_data[i] : 8'hxx;
      checks++; if (b !== exp_msg[i]) begin errors++; $display("FAIL single_byte%0d: got %h want %h", i, b, exp_msg[i]); end
    end
    checks++; if (st_cyc.size() < 1 || st_cyc[0] !== k + 1) begin errors++; $display("FAIL latency_first: got cycle %0d want %0d", st_cyc.size() ? st_cyc[0] : -1, k + 1); end
    checks++; if (td_cyc.size() !== 14) begin errors++; $display("FAIL single_txdone_count: got %0d want 14", td_cyc.size()); end
    for (int i = 1; i < 14 && i < st_cyc.size() && i <= td_cyc.size(); i++) begin
      checks++; if (st_cyc[i] !== td_cyc[i-1] + 2) begin errors++; $display("FAIL per_byte_lat%0d: got %0d want %0d", i, st_cyc[i], td_cyc[i-1] + 2); end
    end
    checks++; if (dn_cyc.size() !== 1) begin errors++; $display("FAIL single_done_count: got %0d want 1", dn_cyc.size()); end
    checks++; if (dn_cyc.size() < 1 || td_cyc.size() < 14 || dn_cyc[0] !== td_cyc[13] + 1) begin errors++; $display("FAIL single_done_time: got %0d want %0d", dn_cyc.size() ? dn_cyc[0] : -1, td_cyc.size() >= 14 ? td_cyc[13] + 1 : -1); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b want 0", busy_o); end
    model_on = 0;
  endtask
  task automatic test_holdoff();
    int k;
    do_reset();
    clear_logs();
    tx_busy_i = 1'b1;
    pulse_en(k);
    step();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (tx_start_o !== 1'b0) begin errors++; $display("FAIL holdoff_start%0d: got %b want 0", i, tx_start_o); end
      checks++; if (tx_data_o !== 8'h68) begin errors++; $display("FAIL holdoff_data%0d: got %h want 68", i, tx_data_o); end
      step();
    end
    tx_busy_i = 1'b0;
    @(negedge clk);
    checks++; if (tx_start_o !== 1'b1) begin errors++; $display("FAIL holdoff_release: got %b want 1", tx_start_o); end
    step();
    @(negedge clk);
    checks++; if (tx_start_o !== 1'b0) begin errors++; $display("FAIL holdoff_single: got %b want 0", tx_start_o); end
    checks++; if (st_data.size() !== 1) begin errors++; $display("FAIL holdoff_count: got %0d want 1", st_data.size()); end
    checks++; if (tx_data_o !== 8'h68) begin errors++; $display("FAIL holdoff_data_after: got %h want 68", tx_data_o); end
    do_reset();
  endtask
  task automatic test_queued();
    int k;
    do_reset();
    clear_logs();
    model_on = 1;
    pulse_en(k);
    for (int i = 0; i < 300 && char_idx_o != 4'd5; i++) step();
    repeat (3) begin en_i = 1'b1; step(); en_i = 1'b0; step(); end
    for (int i = 0; i < 1000 && dn_cyc.size() < 2; i++) step();
    repeat (40) step();
    checks++; if (st_data.size() !== 28) begin errors++; $display("FAIL queued_count: got %0d want 28", st_data.size()); end
    for (int i = 0; i < 28; i++) begin
      logic [7:0] b;
      b = (i < st_data.size()) ? st_data[i] : 8'hxx;
      checks++; if (b !== exp_msg[i % 14]) begin errors++; $display("FAIL queued_byte%0d: got %h want %h", i, b, exp_msg[i % 14]); end
    end
    checks++; if (dn_cyc.size() !== 2) begin errors++; $display("FAIL queued_done_count: got %0d want 2", dn_cyc.size()); end
    checks++; if (st_cyc.size() < 15 || dn_cyc.size() < 1 || st_cyc[14] !== dn_cyc[0] + 2) begin errors++; $display("FAIL queued_restart_time: got %0d want %0d", st_cyc.size() > 14 ? st_cyc[14] : -1, dn_cyc.size() ? dn_cyc[0] + 2 : -1); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL queued_busy_end: got %b want 0", busy_o); end
    model_on = 0;
  endtask
  task automatic test_reset_mid();
    int k;
    do_reset();
    clear_logs();
    model_on = 1;
    pulse_en(k);
    for (int i = 0; i < 300 && !(char_idx_o == 4'd7 && tx_busy_i); i++) step();
    checks++; if (char_idx_o !== 4'd7) begin errors++; $display("FAIL midreset_reach: got %0d want 7", char_idx_o); end
    reset_i = 1'b1;
    step();
    @(negedge clk);
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b want 0", busy_o); end
    checks++; if (tx_data_o !== 8'h00) begin errors++; $display("FAIL midreset_data: got %h want 00", tx_data_o); end
    checks++; if (char_idx_o !== 4'd0) begin errors++; $display("FAIL midreset_idx: got %0d want 0", char_idx_o); end
    reset_i = 1'b0;
    clear_logs();
    repeat (20) step();
    checks++; if (st_data.size() !== 0) begin errors++; $display("FAIL midreset_no_start: got %0d want 0", st_data.size()); end
    clear_logs();
    pulse_en(k);
    for (int i = 0; i < 400 && dn_cyc.size() == 0; i++) step();
    repeat (3) step();
    checks++; if (st_data.size() !== 14) begin errors++; $display("FAIL midreset_resend_count: got %0d want 14", st_data.size()); end
    checks++; if (st_data.size() < 1 || st_data[0] !== 8'h68) begin errors++; $display("FAIL midreset_first: got %h want 68", st_data.size() ? st_data[0] : 8'hxx); end
    checks++; if (st_data.size() < 14 || st_data[13] !== 8'h0A) begin errors++; $display("FAIL midreset_last: got %h want 0a", st_data.size() > 13 ? st_data[13] : 8'hxx); end
    model_on = 0;
  endtask
  task automatic test_nocrlf();
    bit got;
    clear_logs();
    repeat (3) begin done0_i = 1'b1; step(); done0_i = 1'b0; step(); end
    checks++; if (st0_data.size() !== 0) begin errors++; $display("FAIL nocrlf_stray: got %0d starts want 0", st0_data.size()); end
    checks++; if (busy0_o !== 1'b0) begin errors++; $display("FAIL nocrlf_stray_busy: got %b want 0", busy0_o); end
    en0 = 1'b1;
    step();
    en0 = 1'b0;
    for (int b = 0; b < 12; b++) begin
      got = 0;
      for (int t = 0; t < 10 && !got; t++) begin @(negedge clk); got = tx_start0; end
      if (got) begin step(); step(); done0_i = 1'b1; step(); done0_i = 1'b0; end
    end
    repeat (10) step();
    checks++; if (st0_data.size() !== 12) begin errors++; $display("FAIL nocrlf_count: got %0d want 12", st0_data.size()); end
    for (int i = 0; i < 12; i++) begin
      logic [7:0] b;
      b = (i < st0_data.size()) ? st0_data[i] : 8'hxx;
      checks++; if (b !== exp_msg[i]) begin errors++; $display("FAIL nocrlf_byte%0d: got %h want %h", i, b, exp_msg[i]); end
    end
    checks++; if (dn0 !== 1) begin errors++; $display("FAIL nocrlf_done: got %0d want 1", dn0); end
    checks++; if (busy0_o !== 1'b0) begin errors++; $display("FAIL nocrlf_busy_end: got %b want 0", busy0_o); end
  endtask
  initial begin
    test_reset();
    test_single();
    test_holdoff();
    test_queued();
    test_reset_mid();
    test_nocrlf();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
